// File: rtl/display_arbiter_if.sv
// Request/grant bundle between the two display requesters and display_arbiter.
// The master side drives the requests and values. The slave side (the arbiter) drives grant and the display value.
interface display_arbiter_if;
  logic [1:0]  req;
  logic [13:0] value0;
  logic [13:0] value1;
  logic [1:0]  grant;
  logic [13:0] displayValue;
  logic        busy;
  logic        overflow;

  modport master (
    output req, value0, value1,
    input  grant, displayValue, busy, overflow
  );

  modport slave (
    input  req, value0, value1,
    output grant, displayValue, busy, overflow
  );
endinterface

// File: rtl/display_arbiter.sv
// Two-requester arbiter for the four-digit display. It uses round-robin with a minimum hold time and clamps values to 9999.
// Optional macro DISPLAY_PRIORITY_EN: requester 0 gets fixed priority and preempts requester 1 immediately.
module display_arbiter #(
  parameter int HOLD_MS = 500,
  parameter int CNT_W   = 10
) (
  input  logic             clock_1KHz,
  input  logic             reset,
  display_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  localparam logic [13:0]      MAX_VAL  = 14'd9999;
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MS);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [13:0]      disp_q, disp_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [13:0]      value_sel;
  logic             req_own;
  logic             req_oth;
  logic             preempt;

  function automatic logic [13:0] clamp_val(input logic [13:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Pick the owner from a non-zero request vector. A tie goes to whoever did not own the display last.
  function automatic logic pick_owner(input logic [1:0] r, input logic last);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
`ifdef DISPLAY_PRIORITY_EN
    return 1'b0;
`else
    return ~last;
`endif
  endfunction

  assign value_sel = owner_q ? bus.value1 : bus.value0;
  assign req_own   = bus.req[owner_q];
  assign req_oth   = bus.req[~owner_q];

`ifdef DISPLAY_PRIORITY_EN
  assign preempt = owner_q & bus.req[0];
`else
  assign preempt = req_oth && (cnt_q == HOLD_CNT);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, GAP: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        if (bus.req != 2'b00) begin
          state_d = SERVE;
          owner_d = pick_owner(bus.req, last_q);
          grant_d = owner_d ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        disp_d = clamp_val(value_sel);
        ovf_d  = (value_sel > MAX_VAL);
        if (cnt_q != HOLD_CNT) cnt_d = cnt_q + 1'b1;
        if (!req_own || preempt) begin
          state_d = GAP;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_1KHz) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.displayValue = disp_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single four-digit seven-segment display between two requesters, e.g. NES button/state readout (requester 0) and a score/counter (requester 1).
- Drives the display's 14-bit displayValue input through a request/grant handshake.
- Enforces a minimum on-screen hold time and uses round-robin fairness.
- Clamps out-of-range values to 9999.

Parameters:
- HOLD_MS, 500: minimum clock_1KHz cycles a granted requester owns the display before it can be preempted by the other requester.
- CNT_W, 10: width of the hold counter; must satisfy 2^CNT_W > HOLD_MS.

Ports:
- clock_1KHz  input  1  system clock (1 kHz display tick domain)
- reset  input  1  synchronous, active-high reset
- req  input  2  request lines; req[i]=1 means requester i wants the display
- value0  input  14  value from requester 0, unsigned
- value1  input  14  value from requester 1, unsigned
- grant  output  2  one-hot or zero grant, registered
- displayValue  output  14  value to the display, registered, range 0..9999
- busy  output  1  1 while in SERVE
- overflow  output  1  1 when the currently latched displayValue was clamped

Behaviour:
- Interface: one clock, clock_1KHz; reset is synchronous and active-high, port name reset. Everything updates on the rising edge only.
- Reset values: state=IDLE, grant=2'b00, displayValue=0, busy=0, overflow=0, hold counter=0, last-owner pointer=1, so requester 0 wins the first tie. Reset asserted mid-SERVE aborts the grant on the next edge; no value is retained.
- States: IDLE, SERVE, GAP.
- IDLE: if req != 0, go to SERVE and set the owner.
  - Only one req bit set: that requester is the owner.
  - Both set: owner = the requester that is not the last owner (round-robin).
  - grant[owner] and busy rise on the same edge; hold counter clears to 0.
- SERVE: each cycle, displayValue <= clamp(value_owner) and overflow <= (value_owner > 9999).
  - Latency: value sampled at edge N appears at edge N+1; first valid value is one cycle after grant rises.
  - Hold counter increments and saturates at HOLD_MS.
  - req[owner] falls, any count: go to GAP; grant, busy -> 0; last owner <= owner.
  - counter == HOLD_MS and req[other] == 1 and req[owner] still 1: preempt; go to GAP, last owner <= owner.
  - Otherwise remain in SERVE. An owner with no competitor may hold indefinitely.
- GAP: exactly one cycle with grant=0; displayValue and overflow hold. Then arbitrate as in IDLE on the next edge; if no req, go to IDLE.
- IDLE and GAP: displayValue and overflow hold their last value (no blanking, no flicker to 0).
- Clamp: unsigned compare against 9999; values 10000..16383 output 9999. Width is 14 bits throughout, with no truncation.
- Requester 0 and requester 1 both rising in the same IDLE cycle: resolved by the round-robin pointer.
- grant is never two-hot. It is 0 in IDLE, GAP and reset.

Optional Feature:
- DISPLAY_PRIORITY_EN defined: requester 0 has fixed priority.
  - In SERVE with owner=1, req[0]=1 preempts immediately, ignoring HOLD_MS, via GAP.
  - Ties in IDLE/GAP always go to requester 0.
  - Requester 0 is never preempted by requester 1.
- Not defined: symmetric round-robin with HOLD_MS as described above.

Test Plan:
- Reset: hold reset=1 for 3 cycles with req=2'b11 -> grant=00, displayValue=0, busy=0, overflow=0 throughout; release -> grant=01 on the first edge after reset deasserts.
- Single requester: req=01, value0=1234 -> grant=01 after 1 edge, displayValue=1234 after the next edge. Change value0 to 42 -> displayValue=42 one cycle later. Drop req -> grant=00 next edge, displayValue stays 42.
- Clamp: owner=1, value1=12000 -> displayValue=9999, overflow=1. Set value1=9999 -> overflow=0. Set value1=16383 -> 9999, overflow=1.
- Hold/preempt, HOLD_MS=500, macro off: req=01 then req=11 at cycle 10 -> grant stays 01 until counter reaches 500, then 1 GAP cycle with grant=00, then grant=10. No switch occurs before cycle 500 of SERVE.
- Round-robin tie: after owner 0 releases, raise req=11 during GAP -> grant=10. Next tie after owner 1 releases -> grant=01.
- DISPLAY_PRIORITY_EN: owner=1 serving for 5 cycles, raise req[0] -> GAP next edge, grant=01 the edge after. With owner=0 and req[1] held for 2000 cycles -> grant stays 01.
